// File: rtl/mult_hub_arbiter.sv
// rtl/mult_hub_arbiter.sv - round-robin shared HUB FP multiplier with registered operand and result stages
// Carries the winning requester ID alongside each product so results can be routed back.

module multHUB #(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic [E+M:0] x_i,
  input  logic [E+M:0] y_i,
  output logic [E+M:0] z_o
);
  localparam logic signed [E+2:0] BIAS_W = (E+3)'((1 << (E-1)) - 1);

  logic                  sign;
  logic [E-1:0]          ex;
  logic [E-1:0]          ey;
  logic [M+1:0]          sx;
  logic [M+1:0]          sy;
  logic [2*M+3:0]        prod;
  logic                  norm;
  logic [M-1:0]          mant;
  logic signed [E+2:0]   e_sum;
  logic                  unused_prod_bits;

  // HUB significands carry an implicit trailing one; truncating the product is round-to-nearest.
  always_comb begin
    sign  = x_i[E+M] ^ y_i[E+M];
    ex    = x_i[E+M-1:M];
    ey    = y_i[E+M-1:M];
    sx    = {1'b1, x_i[M-1:0], 1'b1};
    sy    = {1'b1, y_i[M-1:0], 1'b1};
    prod  = {{(M+2){1'b0}}, sx} * {{(M+2){1'b0}}, sy};
    norm  = prod[2*M+3];
    mant  = norm ? prod[2*M+2 -: M] : prod[2*M+1 -: M];
    e_sum = $signed({3'b000, ex}) + $signed({3'b000, ey})
          + $signed({{(E+2){1'b0}}, norm}) - BIAS_W;
    z_o   = {sign, e_sum[E-1:0], mant};
    if ((&ex) || (&ey)) begin
      z_o = {sign, {E{1'b1}}, {M{1'b0}}};
    end else if ((ex == '0) || (ey == '0)) begin
      z_o = {sign, {(E+M){1'b0}}};
    end else if (e_sum[E+2] || (e_sum == '0)) begin
      z_o = {sign, {(E+M){1'b0}}};
    end else if (e_sum[E+1:0] >= {2'b00, {E{1'b1}}}) begin
      z_o = {sign, {E{1'b1}}, {M{1'b0}}};
    end
  end

  assign unused_prod_bits = ^prod[M+1:0];
endmodule

module mult_hub_arbiter #(
  parameter int M = 23,
  parameter int E = 8,
  parameter int N = 4,
  localparam int IDW = $clog2(N),
  localparam int W = E + M + 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [N-1:0]   req_valid_i,
  output logic [N-1:0]   req_ready_o,
  input  logic [N*W-1:0] req_x_i,
  input  logic [N*W-1:0] req_y_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W-1:0]   out_z_o,
  output logic [IDW-1:0] out_id_o,
  output logic           out_special_o,
  output logic           busy_o
);
  localparam logic [IDW:0]   N_W     = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

  logic           a_vld_q, a_vld_d;
  logic [W-1:0]   a_x_q, a_x_d;
  logic [W-1:0]   a_y_q, a_y_d;
  logic [IDW-1:0] a_id_q, a_id_d;
  logic           b_vld_q, b_vld_d;
  logic [W-1:0]   z_q, z_d;
  logic [IDW-1:0] id_q, id_d;
  logic           special_q, special_d;
  logic [IDW-1:0] rr_q, rr_d;

  logic           a_adv;
  logic           b_adv;
  logic           found;
  logic           grant;
  logic [IDW-1:0] winner;
  logic [IDW:0]   cand;
  logic [W-1:0]   prod_z;

  multHUB #(.M(M), .E(E)) u_mult (
    .x_i (a_x_q),
    .y_i (a_y_q),
    .z_o (prod_z)
  );

  always_comb begin
    b_adv  = !b_vld_q || out_ready_i;
    a_adv  = !a_vld_q || b_adv;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    // Search starts at the pointer and wraps modulo N.
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found && req_valid_i[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
    grant       = a_adv && found && rst_n_i;
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  always_comb begin
    a_vld_d   = a_vld_q;
    a_x_d     = a_x_q;
    a_y_d     = a_y_q;
    a_id_d    = a_id_q;
    b_vld_d   = b_vld_q;
    z_d       = z_q;
    id_d      = id_q;
    special_d = special_q;
    rr_d      = rr_q;
    if (b_adv) begin
      b_vld_d = a_vld_q;
      if (a_vld_q) begin
        z_d       = prod_z;
        id_d      = a_id_q;
        special_d = (&prod_z[E+M-1:M]) | ~(|prod_z[E+M-1:M]);
      end
    end
    if (a_adv) begin
      a_vld_d = grant;
      if (grant) begin
        a_x_d  = req_x_i[winner*W +: W];
        a_y_d  = req_y_i[winner*W +: W];
        a_id_d = winner;
        rr_d   = (winner == LAST_ID) ? '0 : winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_vld_q   <= 1'b0;
      a_x_q     <= '0;
      a_y_q     <= '0;
      a_id_q    <= '0;
      b_vld_q   <= 1'b0;
      z_q       <= '0;
      id_q      <= '0;
      special_q <= 1'b0;
      rr_q      <= '0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_x_q     <= a_x_d;
      a_y_q     <= a_y_d;
      a_id_q    <= a_id_d;
      b_vld_q   <= b_vld_d;
      z_q       <= z_d;
      id_q      <= id_d;
      special_q <= special_d;
      rr_q      <= rr_d;
    end
  end

  assign out_valid_o   = b_vld_q;
  assign out_z_o       = z_q;
  assign out_id_o      = id_q;
  assign out_special_o = special_q;
  assign busy_o        = a_vld_q | b_vld_q;
endmodule
